bus_debug_bridge: RTL and testbench
===================================

Name: bus_debug_bridge

Overview:
Byte-stream-to-system-bus initiator: consumes command bytes from a byte source (typically the UART RX path), issues single 32-bit bus reads/writes as a bus master, and returns status/data bytes to a byte sink (UART TX path). It sits on a spare BusAccess port beside the CPU and DMA, giving a host PC direct peek/poke access to ROM, RAM and all peripherals.

Parameters:
BUS_TIMEOUT, 1024, cycles to wait for i_bus_ready before aborting a bus access
RX_TIMEOUT, 100000000, idle cycles between bytes of a partial command before it is discarded

Ports:
i_clock  in  1  system clock
i_reset_n  in  1  asynchronous active-low reset
i_rx_valid  in  1  command byte available
i_rx_data  in  8  command byte
o_rx_ready  out  1  bridge accepts i_rx_data this cycle
o_tx_valid  out  1  response byte valid
o_tx_data  out  8  response byte
i_tx_ready  in  1  sink accepts o_tx_data this cycle
o_bus_rw  out  1  1=write, 0=read
o_bus_request  out  1  bus access request
i_bus_ready  in  1  responder completion
o_bus_address  out  32  bus address
i_bus_rdata  in  32  read data
o_bus_wdata  out  32  write data

Behaviour:
- Interface: one clock, i_clock; reset i_reset_n is asynchronous, active-low. Every register clears on reset assertion, regardless of the clock.
- Reset values: o_rx_ready=0, o_tx_valid=0, o_tx_data=0, o_bus_request=0, o_bus_rw=0, o_bus_address=0, o_bus_wdata=0.
- Byte handshake on both sides: a transfer occurs on a rising edge where valid&&ready=1. o_tx_data is held stable while o_tx_valid=1 and i_tx_ready=0.
- Command format; all multi-byte fields are little-endian, LSB first:
  - 0x01 WRITE: opcode, 4 address bytes, 4 data bytes.
  - 0x02 READ: opcode, 4 address bytes.
- Responses:
  - WRITE ok: 0x80.
  - READ ok: 0x80 followed by 4 rdata bytes, LSB first.
  - Bus timeout: 0xE1 only, for both reads and writes.
  - Unknown opcode: 0xE0.
- FSM states: IDLE, ADDR, WDATA, BUS, RESP.
  - IDLE: o_rx_ready=1. On an accepted byte: 0x01/0x02 latches the opcode and goes to ADDR with byte count 0. Any other value loads response 0xE0 and goes to RESP.
  - ADDR: o_rx_ready=1. Each accepted byte shifts into o_bus_address[8*n+:8]. After the 4th byte: WRITE goes to WDATA, READ goes to BUS.
  - WDATA: same as ADDR, filling o_bus_wdata. After the 4th byte, go to BUS.
  - BUS: o_rx_ready=0. o_bus_request=1 from the first cycle in BUS. o_bus_rw=1 for WRITE, 0 for READ. Address, wdata and rw stay stable while request is high.
    - On the cycle i_bus_ready=1 is sampled: latch i_bus_rdata (READ), drop o_bus_request on the next cycle, go to RESP with status 0x80.
    - If ready is not seen within BUS_TIMEOUT cycles: drop request, go to RESP with status 0xE1, discard rdata.
  - RESP: o_rx_ready=0. Emit the status byte, then for READ ok the 4 data bytes. Return to IDLE after the last byte is accepted. Response length is 1, or 5 for READ ok.
- Back-to-back: the bridge can accept a new opcode in the first cycle after returning to IDLE.
- RX_TIMEOUT: in ADDR or WDATA, a 32-bit idle counter increments each cycle with no accepted byte and resets on each accepted byte. When it reaches RX_TIMEOUT, the partial command is dropped: go to IDLE, no response, no bus access.
- Bus latency: o_bus_request rises on the cycle after the final command byte is accepted. The minimum read turnaround is last-byte-in, then request, then ready, then the first tx byte on the following cycle.
- i_bus_ready seen while not in BUS is ignored.
- i_rx_valid while o_rx_ready=0 is not consumed; the source holds the byte.
- Reset mid-operation (any state) returns to IDLE with all outputs at reset values. An in-flight bus request is abandoned immediately.

Test Plan:
- Write: send 01 00 00 00 10 EF BE AD DE → one bus write, addr=0x10000000, wdata=0xDEADBEEF, rw=1; request held until ready (ready after 3 cycles); tx = 80.
- Read: send 02 04 00 00 50, responder returns 0x12345678 → rw=0, addr=0x50000004; tx = 80 78 56 34 12. With i_tx_ready toggling 1/0, every byte is delivered exactly once, unchanged.
- Bus timeout: BUS_TIMEOUT=16, read to an unmapped address (ready never high) → request high exactly 16 cycles then low; tx = E1 only.
- Bad opcode: send 7F → tx = E0, no bus request. Then a valid read completes normally.
- RX timeout: RX_TIMEOUT=100, send 02 00 00, then stall 100 cycles, then send 02 00 00 00 10 → first command discarded, exactly one bus read at 0x10000000, tx = 80 + 4 data bytes.
- Reset mid-op: assert i_reset_n=0 asynchronously during BUS with request high → request drops without waiting for a clock edge. After release, o_rx_ready=1 and a full write succeeds.

Source files
------------

// File: rtl/bus_debug_bridge.sv
// bus_debug_bridge: byte-stream command decoder driving single 32-bit bus reads/writes with byte responses.
module bus_debug_bridge #(
  parameter int BUS_TIMEOUT = 1024,
  parameter int RX_TIMEOUT  = 100000000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_rx_ready,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_bus_rw,
  output logic        o_bus_request,
  input  logic        i_bus_ready,
  output logic [31:0] o_bus_address,
  input  logic [31:0] i_bus_rdata,
  output logic [31:0] o_bus_wdata
);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;
  state_t      state_q, state_d;
  logic        en_q, wr_q, wr_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, tmr_q, tmr_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  bsel;
  logic        rx_acc, tx_acc;
  // en_q keeps rx_ready low while reset is held and for the first edge after release
  assign o_rx_ready    = en_q && (state_q == IDLE || state_q == ADDR || state_q == WDATA);
  assign o_tx_valid    = state_q == RESP;
  assign bsel          = idx_q[1:0] - 2'd1;
  assign o_tx_data     = (idx_q == 3'd0) ? status_q : rdata_q[{bsel, 3'b000} +: 8];
  assign o_bus_request = state_q == BUS;
  assign o_bus_rw      = wr_q;
  assign o_bus_address = addr_q;
  assign o_bus_wdata   = wdata_q;
  assign rx_acc        = i_rx_valid && o_rx_ready;
  assign tx_acc        = o_tx_valid && i_tx_ready;
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    tmr_d    = tmr_q;
    case (state_q)
      IDLE: if (rx_acc) begin
        idx_d = 3'd0;
        tmr_d = 32'd0;
        if (i_rx_data == 8'h01 || i_rx_data == 8'h02) begin
          wr_d    = i_rx_data == 8'h01;
          state_d = ADDR;
        end else begin
          status_d = 8'hE0;
          state_d  = RESP;
        end
      end
      ADDR, WDATA: if (rx_acc) begin
        tmr_d = 32'd0;
        idx_d = idx_q + 3'd1;
        if (state_q == ADDR) addr_d[{idx_q[1:0], 3'b000} +: 8] = i_rx_data;
        else wdata_d[{idx_q[1:0], 3'b000} +: 8] = i_rx_data;
        if (idx_q == 3'd3) begin
          idx_d   = 3'd0;
          state_d = (state_q == ADDR && wr_q) ? WDATA : BUS;
        end
      end else if (tmr_q == 32'(RX_TIMEOUT - 1)) state_d = IDLE;
      else tmr_d = tmr_q + 32'd1;
      BUS: if (i_bus_ready) begin
        if (!wr_q) rdata_d = i_bus_rdata;
        status_d = 8'h80;
        idx_d    = 3'd0;
        state_d  = RESP;
      end else if (tmr_q == 32'(BUS_TIMEOUT - 1)) begin
        status_d = 8'hE1;
        idx_d    = 3'd0;
        state_d  = RESP;
      end else tmr_d = tmr_q + 32'd1;
      RESP: if (tx_acc) begin
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd4 || status_q != 8'h80 || wr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      status_q <= 8'd0;
      tmr_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      en_q     <= 1'b1;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      tmr_q    <= tmr_d;
    end
  end
endmodule

// File: tb/tb_bus_debug_bridge.sv
// tb_bus_debug_bridge: table of commands with scoreboarded bus ops and response bytes, plus timeout/reset sequences.
module tb_bus_debug_bridge;
  logic clk = 0, rst_n = 0, rx_valid = 0, tx_ready = 0, bus_ready = 0;
  logic [7:0] rx_data = 0;
  logic [31:0] bus_rdata = 0;
  logic rx_ready, tx_valid, bus_rw, bus_req;
  logic [7:0] tx_data;
  logic [31:0] bus_addr, bus_wdata;
  always #5 clk = ~clk;
  bus_debug_bridge #(.BUS_TIMEOUT(16), .RX_TIMEOUT(100)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_rx_valid(rx_valid), .i_rx_data(rx_data), .o_rx_ready(rx_ready),
    .o_tx_valid(tx_valid), .o_tx_data(tx_data), .i_tx_ready(tx_ready), .o_bus_rw(bus_rw),
    .o_bus_request(bus_req), .i_bus_ready(bus_ready), .o_bus_address(bus_addr),
    .i_bus_rdata(bus_rdata), .o_bus_wdata(bus_wdata));
  typedef struct packed {
    logic rw; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; logic [31:0] lat; logic [31:0] blen;
  } op_t;
  typedef struct packed {
    logic [31:0] n; logic [71:0] cmd; logic bus; op_t op; logic [31:0] tn; logic [39:0] tx;
  } vec_t;
  logic [7:0] txq[$];
  op_t busq[$];
  op_t cur = '0;
  int total = 0, bad = 0, bcnt = 0;
  logic abort = 0, pv = 0, pr = 0;
  logic [7:0] pd = 0, ex;
  // tx sink alternates ready every cycle; bytes are checked at the negedge before the accepting edge
  always @(negedge clk) begin
    if (pv && !pr) begin
      total++;
      if (!(tx_valid && tx_data == pd)) begin
        bad++;
        $display("FAIL tx_hold got v=%0b d=%h want v=1 d=%h", tx_valid, tx_data, pd);
      end
    end
    tx_ready = ~tx_ready;
    if (tx_valid && tx_ready) begin
      total++;
      if (txq.size() == 0) begin
        bad++;
        $display("FAIL tx_extra got %h want none", tx_data);
      end else begin
        ex = txq.pop_front();
        if (tx_data !== ex) begin
          bad++;
          $display("FAIL tx_byte got %h want %h", tx_data, ex);
        end
      end
    end
    pv = tx_valid; pr = tx_ready; pd = tx_data;
  end
  // bus responder: ready in request cycle 'lat' (0 = never); idle ready noise must be ignored
  always @(negedge clk) begin
    if (bus_req) begin
      if (bcnt == 0) begin
        total++;
        if (busq.size() == 0) begin
          bad++; cur = '0;
          $display("FAIL bus_extra got rw=%0b addr=%h want none", bus_rw, bus_addr);
        end else begin
          cur = busq.pop_front();
          if (bus_rw !== cur.rw || bus_addr !== cur.addr || (cur.rw && bus_wdata !== cur.wdata)) begin
            bad++;
            $display("FAIL bus_op got rw=%0b a=%h d=%h want rw=%0b a=%h d=%h",
                     bus_rw, bus_addr, bus_wdata, cur.rw, cur.addr, cur.wdata);
          end
        end
      end
      bcnt++;
      bus_ready = cur.lat != 0 && bcnt == int'(cur.lat);
      bus_rdata = cur.rdata;
    end else begin
      if (bcnt > 0 && !abort) begin
        total++;
        if (bcnt != int'(cur.blen)) begin
          bad++;
          $display("FAIL bus_len got %0d want %0d", bcnt, cur.blen);
        end
      end
      bcnt = 0; abort = 0;
      bus_ready = 1'($urandom_range(0, 1));
      bus_rdata = $urandom;
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_valid = 1; rx_data = b;
    while (!rx_ready && n < 300) begin @(negedge clk); n++; end
    if (!rx_ready) begin
      total++; bad++;
      $display("FAIL rx_wait got ready=0 want ready=1 byte=%h", b);
    end
    @(negedge clk);
    rx_valid = 0; rx_data = 8'($urandom);
  endtask
  task automatic drain(input string nm);
    int n = 0;
    while ((txq.size() != 0 || busq.size() != 0 || !rx_ready) && n < 300) begin @(negedge clk); n++; end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL %s drain got txq=%0d busq=%0d rdy=%0b want 0 0 1", nm, txq.size(), busq.size(), rx_ready);
    end
  endtask
  function automatic vec_t mk(input int n, input logic [71:0] cmd, input logic bus, input logic rw,
                              input logic [31:0] addr, wdata, rdata, input int lat, blen, tn, input logic [39:0] tx);
    vec_t v;
    v.n = n; v.cmd = cmd; v.bus = bus; v.tn = tn; v.tx = tx;
    v.op = '{rw, addr, wdata, rdata, 32'(lat), 32'(blen)};
    return v;
  endfunction
  task automatic apply(input vec_t v);
    for (int i = 0; i < int'(v.tn); i++) txq.push_back(v.tx[8*i +: 8]);
    if (v.bus) busq.push_back(v.op);
    for (int i = 0; i < int'(v.n); i++) send(v.cmd[8*i +: 8]);
  endtask
  vec_t tbl[9];
  initial begin
    tbl[0] = mk(9, {32'hDEADBEEF, 32'h10000000, 8'h01}, 1, 1, 32'h10000000, 32'hDEADBEEF, 0, 3, 3, 1, 40'h80);
    tbl[1] = mk(5, {32'h0, 32'h50000004, 8'h02}, 1, 0, 32'h50000004, 0, 32'h12345678, 2, 2, 5, {32'h12345678, 8'h80});
    tbl[2] = mk(5, {32'h0, 32'hF0000000, 8'h02}, 1, 0, 32'hF0000000, 0, 32'h99999999, 0, 16, 1, 40'hE1);
    tbl[3] = mk(1, 72'h7F, 0, 0, 0, 0, 0, 0, 0, 1, 40'hE0);
    tbl[4] = mk(5, {32'h0, 32'h20000008, 8'h02}, 1, 0, 32'h20000008, 0, 32'hA5A55A5A, 1, 1, 5, {32'hA5A55A5A, 8'h80});
    tbl[5] = mk(9, {32'h01020304, 32'h40000000, 8'h01}, 1, 1, 32'h40000000, 32'h01020304, 0, 0, 16, 1, 40'hE1);
    tbl[6] = mk(1, 72'h00, 0, 0, 0, 0, 0, 0, 0, 1, 40'hE0);
    tbl[7] = mk(1, 72'hFF, 0, 0, 0, 0, 0, 0, 0, 1, 40'hE0);
    tbl[8] = mk(9, {32'hCAFEF00D, 32'h00000100, 8'h01}, 1, 1, 32'h00000100, 32'hCAFEF00D, 0, 1, 1, 1, 40'h80);
    #12;
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_tx_valid", 32'(tx_valid), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_bus_req", 32'(bus_req), 0);
    chk("rst_bus_rw", 32'(bus_rw), 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("rx_ready_after_reset", 32'(rx_ready), 1);
    for (int i = 0; i < 9; i++) begin
      apply(tbl[i]);
      drain($sformatf("vec%0d", i));
    end
    // partial read abandoned after 100 idle cycles, then a complete read
    send(8'h02); send(8'h00); send(8'h00);
    repeat (100) @(negedge clk);
    apply(mk(5, {32'h0, 32'h10000000, 8'h02}, 1, 0, 32'h10000000, 0, 32'h0BADF00D, 2, 2, 5, {32'h0BADF00D, 8'h80}));
    drain("rx_timeout");
    // async reset while a read is stuck on the bus
    busq.push_back('{1'b0, 32'h30000000, 32'h0, 32'h0, 32'd0, 32'd0});
    send(8'h02); send(8'h00); send(8'h00); send(8'h00); send(8'h30);
    for (int n = 0; n < 20 && !bus_req; n++) @(negedge clk);
    chk("midop_req_high", 32'(bus_req), 1);
    repeat (3) @(negedge clk);
    #2 abort = 1; rst_n = 0;
    #1;
    chk("midop_req_drop", 32'(bus_req), 0);
    chk("midop_rx_ready", 32'(rx_ready), 0);
    chk("midop_addr", bus_addr, 0);
    chk("midop_tx_valid", 32'(tx_valid), 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    chk("midop_ready_back", 32'(rx_ready), 1);
    chk("midop_busq_empty", 32'(busq.size()), 0);
    apply(tbl[0]);
    drain("post_reset_write");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
